ex_muldiv: RTL and testbench
============================

Name: ex_muldiv

Overview:
Iterative RV32M multiply/divide unit in the EX stage. It consumes operands and funct3 from the ID2EX pipeline register output. While it computes, it stalls the front end (ID2EX and upstream) so the M-extension instruction stays in EX. It then presents the 32-bit result to the EX result mux for exactly one accepted cycle.

Parameters:
XLEN, 32, operand and result width; only 32 is supported.
STEPS, XLEN, iteration count for normal operations (one bit per cycle).

Ports:
ACLK  input  1  clock.
ARESET  input  1  asynchronous, active-high reset.
start_i  input  1  instruction currently in EX is an M-extension op (from the decoded ID2EX bus).
op_i  input  3  funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
rs1_i  input  XLEN  operand A (after forwarding).
rs2_i  input  XLEN  operand B (after forwarding).
flush_i  input  1  EX flush (branch or trap); aborts any operation.
hold_i  input  1  downstream stall; the EX result must not be consumed this cycle.
stall_o  output  1  front-end stall request, routed to ID2EX stall_en and the upstream buffers.
result_valid_o  output  1  result_o is valid this cycle.
result_o  output  XLEN  operation result.

Behaviour:
- States: IDLE, BUSY, DONE. Reset, asynchronous and at any point mid-operation: state=IDLE, counter=0, all internal registers 0, result_o=0, result_valid_o=0, stall_o=0.
- stall_o is combinational: high when (state==IDLE or DONE) with start_i=1 and flush_i=0, or when state==BUSY, or when state==DONE with hold_i=1.
- IDLE, start_i=1, flush_i=0 at cycle N:
  - Latch op, operands, and sign flags.
  - Take absolute values: signed for DIV/REM/MULH; rs1 only for MULHSU.
  - Go to BUSY with counter=0.
- BUSY:
  - Multiply: one shift-add step per cycle into a 2*XLEN accumulator.
  - Divide: one restoring subtract step per cycle, producing quotient and remainder.
  - Counter increments each step. After STEPS steps go to DONE: N+1..N+32 are BUSY, DONE at N+33, so stall_o is high N..N+32.
- Special cases detected at capture go straight to DONE at N+1 (stall_o high in N only):
  - Divisor 0: DIV/DIVU give all-ones; REM/REMU give rs1.
  - Signed overflow (rs1=0x80000000, rs2=0xFFFFFFFF, DIV/REM): DIV gives 0x80000000; REM gives 0.
- Result selection in DONE:
  - MUL takes the low word; MULH* take the high word of the 64-bit product.
  - The signed product is negated when the operand signs differ (MULHSU uses rs1's sign only).
  - The quotient is negated when the signs differ.
  - The remainder takes the sign of the dividend.
- DONE: result_valid_o=1 and result_o is held stable.
  - hold_i=1: stay in DONE with the same result.
  - hold_i=0, start_i=0: go to IDLE.
  - hold_i=0, start_i=1: the next M-op is already in EX. Capture it as from IDLE and go to BUSY (or to DONE for a special case). Back-to-back operations need no idle bubble.
- flush_i=1 in any state:
  - Next state is IDLE with result_valid_o=0 next cycle; result_valid_o is also forced to 0 combinationally in the flush cycle.
  - A simultaneous start_i is ignored and stall_o=0.
  - Flush has priority over start and hold.
- All arithmetic is unsigned on magnitude registers. Negation is two's complement within the width, and wrap-around is intentional (MUL keeps the low 32 bits only).

Decomposition:
- Shared CPU package holds:
  - muldiv_op_e enum (funct3 encodings above).
  - muldiv_state_e (IDLE/BUSY/DONE).
  - MULDIV_STEPS constant.
  - M-ext decode flag field added to id_ex_bus_t.
- One sub-module, ex_muldiv_iter: the per-cycle shift-add / restoring-subtract datapath step (accumulator, quotient, and remainder registers plus counter). The FSM, special-case detection, and sign fixup stay in ex_muldiv.

Test Plan:
- MUL rs1=7, rs2=0xFFFFFFFD, start at cycle 0 -> stall_o high cycles 0-32; result_valid_o=1 at cycle 33 with result 0xFFFFFFEB.
- MULH 0x80000000*0x80000000 -> 0x40000000. MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF.
- DIV rs1=0xFFFFFFF9 (-7), rs2=2 -> 0xFFFFFFFD; REM -> 0xFFFFFFFF. DIVU 100/7 -> 14; REMU -> 2.
- Divide by zero:
  - DIV 5/0 -> 0xFFFFFFFF at cycle 1; REMU 5/0 -> 5. stall_o high only in cycle 0.
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000 at cycle 1; REM -> 0.
- flush_i at BUSY cycle 10 -> IDLE at cycle 11, no result_valid_o. A new DIVU 9/3 started at cycle 11 yields 3 at cycle 44.
- hold_i=1 for 3 cycles in DONE -> result_valid_o and result_o stable, stall_o high; release with start_i=1 -> the next op is captured the same cycle.
- ARESET pulsed mid-BUSY at cycle 5 -> all outputs 0 immediately and IDLE; the next start has normal 33-cycle latency.

Source files
------------

// File: rtl/ex_muldiv_pkg.sv
// Shared CPU definitions for the EX-stage RV32M multiply/divide unit.
// Holds the M-extension funct3 encodings, the unit's FSM states, the
// iteration count and the ID2EX bus payload carrying the M-ext decode flag.
package ex_muldiv_pkg;

    localparam int unsigned MULDIV_XLEN  = 32;
    localparam int unsigned MULDIV_STEPS = MULDIV_XLEN;

    // funct3 of OP/M-extension instructions
    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } muldiv_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } muldiv_state_e;

    // Decoded ID2EX payload; is_mext routes the instruction to ex_muldiv
    typedef struct packed {
        logic                   valid;
        logic                   is_mext;
        muldiv_op_e             funct3;
        logic [4:0]             rd;
        logic [MULDIV_XLEN-1:0] rs1_val;
        logic [MULDIV_XLEN-1:0] rs2_val;
    } id_ex_bus_t;

endpackage

// File: rtl/ex_muldiv_iter.sv
// Per-cycle datapath step for ex_muldiv.
// Multiply: shift-add into a 2*XLEN accumulator whose low half starts as the
// multiplier. Divide: restoring subtract, dividend shifts out of the quotient
// register into the remainder. Both step in parallel; the top picks one.
// Ports: load_i (capture magnitudes, clear counter), step_i (advance one bit),
// div_i (operand routing at load), a_i/b_i (magnitudes), *_nxt_c (value the
// registers take on this step), last_c (this step is the final one).
module ex_muldiv_iter
    import ex_muldiv_pkg::*;
#(
    parameter int unsigned XLEN  = MULDIV_XLEN,
    parameter int unsigned STEPS = MULDIV_STEPS
) (
    input  logic              ACLK,
    input  logic              ARESET,
    input  logic              load_i,
    input  logic              step_i,
    input  logic              div_i,
    input  logic [XLEN-1:0]   a_i,
    input  logic [XLEN-1:0]   b_i,
    output logic [2*XLEN-1:0] acc_nxt_c,
    output logic [XLEN-1:0]   quo_nxt_c,
    output logic [XLEN-1:0]   rem_nxt_c,
    output logic              last_c
);

    localparam int unsigned CNT_W = $clog2(STEPS + 1);

    logic [2*XLEN-1:0] acc_q;
    logic [XLEN-1:0]   opnd_q;
    logic [XLEN-1:0]   quo_q;
    logic [XLEN-1:0]   rem_q;
    logic [CNT_W-1:0]  cnt_q;

    logic [XLEN:0]     sum_c;
    logic [XLEN:0]     shl_c;
    logic [XLEN:0]     diff_c;
    logic              ge_c;

    // One shift-add and one restoring-subtract step
    always_comb begin
        sum_c     = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        acc_nxt_c = {sum_c, acc_q[XLEN-1:1]};
        shl_c     = {rem_q, quo_q[XLEN-1]};
        diff_c    = shl_c - {1'b0, opnd_q};
        // remainder < divisor keeps |diff| below 2^XLEN, so the top bit is the borrow
        ge_c      = ~diff_c[XLEN];
        rem_nxt_c = ge_c ? diff_c[XLEN-1:0] : shl_c[XLEN-1:0];
        quo_nxt_c = {quo_q[XLEN-2:0], ge_c};
        last_c    = step_i && (cnt_q == CNT_W'(STEPS - 1));
    end

    // Operand capture and iteration registers
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            acc_q  <= '0;
            opnd_q <= '0;
            quo_q  <= '0;
            rem_q  <= '0;
            cnt_q  <= '0;
        end else if (load_i) begin
            acc_q  <= {{XLEN{1'b0}}, b_i};
            opnd_q <= div_i ? b_i : a_i;
            quo_q  <= a_i;
            rem_q  <= '0;
            cnt_q  <= '0;
        end else if (step_i) begin
            acc_q  <= acc_nxt_c;
            quo_q  <= quo_nxt_c;
            rem_q  <= rem_nxt_c;
            cnt_q  <= cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/ex_muldiv.sv
// Iterative RV32M multiply/divide unit in the EX stage.
// Holds the front end via stall_o while an M-op computes, then presents the
// result for one accepted cycle (longer while hold_i is high).
// Ports: ACLK/ARESET (async active-high), start_i/op_i/rs1_i/rs2_i (M-op in EX),
// flush_i (abort), hold_i (downstream stall), stall_o (combinational front-end
// stall), result_valid_o/result_o (result to the EX result mux).
module ex_muldiv
    import ex_muldiv_pkg::*;
#(
    parameter int unsigned XLEN  = MULDIV_XLEN,
    parameter int unsigned STEPS = MULDIV_STEPS
) (
    input  logic            ACLK,
    input  logic            ARESET,
    input  logic            start_i,
    input  logic [2:0]      op_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    input  logic            flush_i,
    input  logic            hold_i,
    output logic            stall_o,
    output logic            result_valid_o,
    output logic [XLEN-1:0] result_o
);

    muldiv_state_e     state_q, state_nxt;
    muldiv_op_e        op_c, op_q;
    logic              neg_q;

    logic              signed_a_c, signed_b_c, a_neg_c, b_neg_c, neg_c;
    logic [XLEN-1:0]   a_mag_c, b_mag_c;
    logic              div_zero_c, ovf_c, special_c;
    logic [XLEN-1:0]   special_res_c;
    logic              capture_c, step_c;

    logic [2*XLEN-1:0] acc_nxt_c, prod_c;
    logic [XLEN-1:0]   quo_nxt_c, rem_nxt_c, div_val_c, fix_res_c;
    logic              last_c, is_div_q, is_rem_q;

    // Operand decode: sign handling and special cases resolved at capture
    always_comb begin
        op_c       = muldiv_op_e'(op_i);
        signed_a_c = (op_c == OP_MULH) || (op_c == OP_MULHSU) ||
                     (op_c == OP_DIV)  || (op_c == OP_REM);
        signed_b_c = (op_c == OP_MULH) || (op_c == OP_DIV) || (op_c == OP_REM);
        a_neg_c    = signed_a_c & rs1_i[XLEN-1];
        b_neg_c    = signed_b_c & rs2_i[XLEN-1];
        a_mag_c    = a_neg_c ? -rs1_i : rs1_i;
        b_mag_c    = b_neg_c ? -rs2_i : rs2_i;
        // REM follows the dividend; products and quotients follow the sign difference
        neg_c      = (op_c == OP_REM) ? a_neg_c : (a_neg_c ^ b_neg_c);
        div_zero_c = op_i[2] && (rs2_i == '0);
        ovf_c      = ((op_c == OP_DIV) || (op_c == OP_REM)) &&
                     (rs1_i == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_i == '1);
        special_c  = div_zero_c | ovf_c;
        if (div_zero_c) begin
            special_res_c = op_i[1] ? rs1_i : '1;
        end else begin
            special_res_c = op_i[1] ? '0 : rs1_i;
        end
    end

    // Next-state and handshake decode
    always_comb begin
        state_nxt = state_q;
        stall_o   = 1'b0;
        capture_c = 1'b0;
        step_c    = 1'b0;
        if (flush_i) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        stall_o   = 1'b1;
                        capture_c = 1'b1;
                        state_nxt = special_c ? ST_DONE : ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    stall_o = 1'b1;
                    step_c  = 1'b1;
                    if (last_c) begin
                        state_nxt = ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (hold_i) begin
                        stall_o = 1'b1;
                    end else if (start_i) begin
                        // back-to-back M-op captured without an idle bubble
                        stall_o   = 1'b1;
                        capture_c = 1'b1;
                        state_nxt = special_c ? ST_DONE : ST_BUSY;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    // Sign fixup and result selection from the final step
    always_comb begin
        is_div_q  = (op_q == OP_DIV) || (op_q == OP_DIVU) ||
                    (op_q == OP_REM) || (op_q == OP_REMU);
        is_rem_q  = (op_q == OP_REM) || (op_q == OP_REMU);
        prod_c    = neg_q ? -acc_nxt_c : acc_nxt_c;
        div_val_c = is_rem_q ? rem_nxt_c : quo_nxt_c;
        if (is_div_q) begin
            fix_res_c = neg_q ? -div_val_c : div_val_c;
        end else if (op_q == OP_MUL) begin
            fix_res_c = prod_c[XLEN-1:0];
        end else begin
            fix_res_c = prod_c[2*XLEN-1:XLEN];
        end
    end

    assign result_valid_o = (state_q == ST_DONE) && !flush_i;

    // State, captured op and result registers
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_q  <= ST_IDLE;
            op_q     <= OP_MUL;
            neg_q    <= 1'b0;
            result_o <= '0;
        end else begin
            state_q <= state_nxt;
            if (capture_c) begin
                op_q  <= op_c;
                neg_q <= neg_c;
                if (special_c) begin
                    result_o <= special_res_c;
                end
            end else if (step_c && last_c) begin
                result_o <= fix_res_c;
            end
        end
    end

    ex_muldiv_iter #(
        .XLEN  (XLEN),
        .STEPS (STEPS)
    ) u_iter (
        .ACLK      (ACLK),
        .ARESET    (ARESET),
        .load_i    (capture_c),
        .step_i    (step_c),
        .div_i     (op_i[2]),
        .a_i       (a_mag_c),
        .b_i       (b_mag_c),
        .acc_nxt_c (acc_nxt_c),
        .quo_nxt_c (quo_nxt_c),
        .rem_nxt_c (rem_nxt_c),
        .last_c    (last_c)
    );

endmodule

// File: tb/tb_ex_muldiv.sv
// Self-checking bench for ex_muldiv: directed cases, randomized ops against a
// plain-arithmetic reference, flush, hold/back-to-back and mid-op reset.
module tb_ex_muldiv;

    logic        ACLK;
    logic        ARESET;
    logic        start_i;
    logic [2:0]  op_i;
    logic [31:0] rs1_i;
    logic [31:0] rs2_i;
    logic        flush_i;
    logic        hold_i;
    logic        stall_o;
    logic        result_valid_o;
    logic [31:0] result_o;

    int n_cmp = 0;
    int n_err = 0;

    ex_muldiv dut (
        .ACLK           (ACLK),
        .ARESET         (ARESET),
        .start_i        (start_i),
        .op_i           (op_i),
        .rs1_i          (rs1_i),
        .rs2_i          (rs2_i),
        .flush_i        (flush_i),
        .hold_i         (hold_i),
        .stall_o        (stall_o),
        .result_valid_o (result_valid_o),
        .result_o       (result_o)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // RV32M results from 64-bit integer arithmetic
    function automatic logic [31:0] ref_res(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ua, ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        case (op)
            3'd0: begin p = 64'(sa * sb); return p[31:0]; end
            3'd1: begin p = 64'(sa * sb); return p[63:32]; end
            3'd2: begin p = 64'(sa * ub); return p[63:32]; end
            3'd3: begin p = 64'(ua * ub); return p[63:32]; end
            3'd4: begin if (b == 0) return 32'hFFFF_FFFF; p = 64'(sa / sb); return p[31:0]; end
            3'd5: begin if (b == 0) return 32'hFFFF_FFFF; return a / b; end
            3'd6: begin if (b == 0) return a; p = 64'(sa % sb); return p[31:0]; end
            default: begin if (b == 0) return a; return a % b; end
        endcase
    endfunction

    // Cycles from capture to result: 1 for divide-by-zero / signed overflow, else 33
    function automatic int ref_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        if (op >= 3'd4 && b == 0) return 1;
        if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    task automatic chk_bit(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%b expected=%b t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic chk_word(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h t=%0t", tag, obs, exp, $time);
        end
    endtask

    // Issue one op, check stall/valid every cycle, then hold the result hold_n cycles
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_v, input int hold_n);
        int lat;
        lat = ref_lat(op, a, b);
        @(posedge ACLK); #1;
        start_i = 1'b1; op_i = op; rs1_i = a; rs2_i = b; hold_i = 1'b0; flush_i = 1'b0;
        @(negedge ACLK);
        chk_bit("stall_at_start", stall_o, 1'b1);
        for (int k = 1; k <= lat; k++) begin
            @(posedge ACLK); #1;
            start_i = 1'b0;
            hold_i  = (k == lat) && (hold_n > 0);
            @(negedge ACLK);
            chk_bit("valid", result_valid_o, k == lat);
            chk_bit("stall", stall_o, (k < lat) || (hold_n > 0));
            if (k == lat) chk_word("result", result_o, exp_v);
        end
        for (int h = 1; h < hold_n; h++) begin
            @(posedge ACLK); #1;
            hold_i = 1'b1;
            @(negedge ACLK);
            chk_bit("hold_valid", result_valid_o, 1'b1);
            chk_bit("hold_stall", stall_o, 1'b1);
            chk_word("hold_result", result_o, exp_v);
        end
    endtask

    task automatic idle_cycle();
        @(posedge ACLK); #1;
        start_i = 1'b0; hold_i = 1'b0; flush_i = 1'b0;
        @(negedge ACLK);
        chk_bit("idle_valid", result_valid_o, 1'b0);
        chk_bit("idle_stall", stall_o, 1'b0);
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] e;
        int          h;
    } vec_t;

    // Ops with nonzero hold chain straight into the next op while in DONE
    vec_t dir_v [12] = '{
        '{3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 0},
        '{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 0},
        '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 3},
        '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0},
        '{3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 0},
        '{3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 2},
        '{3'd5, 32'd100,       32'd7,         32'd14,        0},
        '{3'd7, 32'd100,       32'd7,         32'd2,         0},
        '{3'd4, 32'd5,         32'd0,         32'hFFFF_FFFF, 1},
        '{3'd7, 32'd5,         32'd0,         32'd5,         0},
        '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0},
        '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 0}
    };

    initial begin
        logic [2:0]  rop;
        logic [31:0] ra, rb;
        int          sel;

        ARESET = 1'b1; start_i = 1'b0; op_i = 3'd0; rs1_i = '0; rs2_i = '0;
        flush_i = 1'b0; hold_i = 1'b0;
        #2;
        chk_bit("reset_stall", stall_o, 1'b0);
        chk_bit("reset_valid", result_valid_o, 1'b0);
        chk_word("reset_result", result_o, 32'd0);
        @(negedge ACLK);
        ARESET = 1'b0;

        // Directed cases, including special-case latency and hold/back-to-back
        for (int i = 0; i < 12; i++) begin
            run_op(dir_v[i].op, dir_v[i].a, dir_v[i].b, dir_v[i].e, dir_v[i].h);
            if (dir_v[i].h == 0) idle_cycle();
        end

        // Randomized ops against the reference
        for (int i = 0; i < 24; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = $urandom;
            rb  = $urandom;
            sel = $urandom_range(0, 7);
            if (sel == 0) rb = 32'd0;
            if (sel == 1) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
            if (sel == 2) rb = 32'($urandom_range(1, 20));
            run_op(rop, ra, rb, ref_res(rop, ra, rb), 0);
            idle_cycle();
        end

        // Flush at BUSY cycle 10, then DIVU 9/3 from cycle 11
        @(posedge ACLK); #1;
        start_i = 1'b1; op_i = 3'd5; rs1_i = 32'd100; rs2_i = 32'd7;
        @(negedge ACLK);
        chk_bit("flush_start_stall", stall_o, 1'b1);
        for (int k = 1; k < 10; k++) begin
            @(posedge ACLK); #1;
            start_i = 1'b0;
            @(negedge ACLK);
            chk_bit("flush_busy_valid", result_valid_o, 1'b0);
        end
        @(posedge ACLK); #1;
        flush_i = 1'b1; start_i = 1'b1;
        @(negedge ACLK);
        chk_bit("flush_valid", result_valid_o, 1'b0);
        chk_bit("flush_stall", stall_o, 1'b0);
        run_op(3'd5, 32'd9, 32'd3, 32'd3, 0);
        idle_cycle();

        // Back-to-back after hold, then flush while in DONE
        run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 3);
        run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 2);
        @(posedge ACLK); #1;
        flush_i = 1'b1; start_i = 1'b1; hold_i = 1'b1;
        @(negedge ACLK);
        chk_bit("done_flush_valid", result_valid_o, 1'b0);
        chk_bit("done_flush_stall", stall_o, 1'b0);
        idle_cycle();

        // Reset asserted mid-BUSY at cycle 5
        @(posedge ACLK); #1;
        start_i = 1'b1; op_i = 3'd0; rs1_i = 32'd3; rs2_i = 32'd5;
        for (int k = 1; k <= 5; k++) begin
            @(posedge ACLK); #1;
            start_i = 1'b0;
        end
        ARESET = 1'b1;
        #1;
        chk_bit("midreset_stall", stall_o, 1'b0);
        chk_bit("midreset_valid", result_valid_o, 1'b0);
        chk_word("midreset_result", result_o, 32'd0);
        @(negedge ACLK);
        ARESET = 1'b0;
        run_op(3'd5, 32'd100, 32'd7, 32'd14, 0);
        idle_cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
